keypad_scanner: RTL and testbench

Scans a 4x4 matrix keypad by driving one row low at a time and reading the four column lines, then debounces the result over whole scans. It reports a stable key press as a 4-bit code with a one-cycle strobe and a sticky pending flag. It sits beside the display multiplexer in the FPGA top and feeds the SoC general-purpose inputs. Where the display multiplexer writes time-multiplexed data out to the board, this block reads time-multiplexed data in.

---
 rtl/keypad_scanner.sv | 255 +++++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// ----------------------------------------------------------------------------
// keypad_scanner
//
// Scans a 4x4 matrix keypad. One row is driven low at a time for SCAN_DIV
// cycles. The four column lines are sampled at the end of each row's dwell,
// and a full 16-bit image is built up over four rows. Each completed scan is
// classified as no key, a single key, or several keys. Several keys are
// treated as ghosting. A single-key or no-key result must repeat over
// DEBOUNCE_SCANS consecutive scans before it is committed. A committed key
// produces a one-cycle strobe and raises a sticky pending flag. A new commit
// while the flag is still pending raises a sticky overrun flag.
//
// Parameters
//   SCAN_DIV        clock cycles each row is driven (>= 4)
//   DEBOUNCE_SCANS  identical consecutive scans needed to commit (>= 2)
//
// Ports
//   clk          system clock
//   rst          asynchronous active-low reset
//   col_in[3:0]  keypad columns, asynchronous, active-low (0 = key closed)
//   key_ack      one-cycle pulse from the consumer; clears pending/overrun
//   row_sel[3:0] registered row drive, one-hot active-low (1110 = row 0)
//   key_code     {row[1:0], col[1:0]} of the last committed key
//   key_valid    high while a committed key is held
//   key_strobe   one-cycle pulse on each newly committed key
//   key_pending  sticky: set by key_strobe, cleared by key_ack
//   overrun      sticky: a new key was committed while key_pending was set
// ----------------------------------------------------------------------------
module keypad_scanner #(
  parameter int SCAN_DIV       = 25000,
  parameter int DEBOUNCE_SCANS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_in,
  input  logic       key_ack,
  output logic [3:0] row_sel,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_strobe,
  output logic       key_pending,
  output logic       overrun
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS);

  // Scan result classification.
  localparam logic [1:0] RES_NONE   = 2'd0;
  localparam logic [1:0] RES_SINGLE = 2'd1;
  localparam logic [1:0] RES_MULTI  = 2'd2;

  // Commit state machine.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HELD = 1'b1;

  // --------------------------------------------------------------------------
  // Column synchronizer. Idle columns are pulled up, so both flops reset to
  // all-ones. That way a reset never looks like a key press.
  // --------------------------------------------------------------------------
  logic [3:0] col_meta;
  logic [3:0] col_sync;

  // NOTE: state is updated with non-blocking assignments, so every flop
  // samples the values from before the edge. Blocking assignments here would
  // collapse the two synchronizer stages into one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_meta <= 4'hF;
      col_sync <= 4'hF;
    end else begin
      col_meta <= col_in;
      col_sync <= col_meta;
    end
  end

  // --------------------------------------------------------------------------
  // Row scan timing. The column sample is taken in the last dwell cycle.
  // This gives the registered row drive and the two synchronizer stages time
  // to settle. The row drive moves on in the cycle after the sample.
  // --------------------------------------------------------------------------
  logic [DW-1:0] dwell_cnt;
  logic [1:0]    row_idx;
  logic [1:0]    row_nxt;
  logic          sample;
  logic          scan_end;

  assign sample   = (dwell_cnt == DWELL_LAST);
  assign scan_end = sample && (row_idx == 2'd3);
  assign row_nxt  = row_idx + 2'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dwell_cnt <= '0;
      row_idx   <= 2'd0;
      row_sel   <= 4'b1110;
    end else if (sample) begin
      dwell_cnt <= '0;
      row_idx   <= row_nxt;
      row_sel   <= ~(4'b0001 << row_nxt);
    end else begin
      dwell_cnt <= dwell_cnt + DW'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Scan image. Rows 0..2 are stored. Row 3 comes straight from the
  // synchronizer in the row-3 sample cycle, so the full image is available
  // in the same cycle the scan ends. Bit (row*4 + col) is 1 when that key is
  // closed, so a set bit's index is already its key code.
  // --------------------------------------------------------------------------
  logic [11:0] img_lo;
  logic [15:0] scan_img;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      img_lo <= '0;
    end else if (sample) begin
      case (row_idx)
        2'd0:    img_lo[3:0]  <= ~col_sync;
        2'd1:    img_lo[7:4]  <= ~col_sync;
        2'd2:    img_lo[11:8] <= ~col_sync;
        default: ;
      endcase
    end
  end

  assign scan_img = {~col_sync, img_lo};

  // --------------------------------------------------------------------------
  // Classification: count the closed keys and remember which one was found.
  // --------------------------------------------------------------------------
  logic [4:0] n_closed;
  logic [3:0] found_code;
  logic [1:0] res_kind;
  logic [3:0] res_code;

  // NOTE: every combinational output gets a default at the top of the block.
  // Otherwise, a path that does not assign it would infer a latch.
  always_comb begin
    n_closed   = '0;
    found_code = '0;
    for (int i = 0; i < 16; i++) begin
      if (scan_img[i]) begin
        n_closed   = n_closed + 5'd1;
        found_code = 4'(i);
      end
    end
  end

  // The code is forced to zero unless the result is SINGLE. This lets two
  // results be compared as a whole.
  always_comb begin
    res_kind = RES_NONE;
    res_code = '0;
    if (n_closed == 5'd1) begin
      res_kind = RES_SINGLE;
      res_code = found_code;
    end else if (n_closed > 5'd1) begin
      res_kind = RES_MULTI;
    end
  end

  // --------------------------------------------------------------------------
  // Debounce counter. It saturates at DEBOUNCE_SCANS, so a held result stays
  // "stable" without wrapping. MULTI always resets the count to zero.
  // --------------------------------------------------------------------------
  logic [SW-1:0] stable_cnt;
  logic [SW-1:0] stable_nxt;
  logic [1:0]    prev_kind;
  logic [3:0]    prev_code;
  logic          is_stable;

  always_comb begin
    stable_nxt = stable_cnt;
    if (res_kind == RES_MULTI) begin
      stable_nxt = '0;
    end else if (res_kind == prev_kind && res_code == prev_code) begin
      stable_nxt = (stable_cnt == STABLE_MAX) ? STABLE_MAX : stable_cnt + SW'(1);
    end else begin
      stable_nxt = SW'(1);
    end
  end

  assign is_stable = (stable_nxt == STABLE_MAX);

  // --------------------------------------------------------------------------
  // Commit state machine. It is evaluated only at scan end. key_code,
  // key_valid and key_strobe all change together in the following cycle.
  // --------------------------------------------------------------------------
  logic [0:0] state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stable_cnt <= '0;
      prev_kind  <= RES_NONE;
      prev_code  <= '0;
      state      <= ST_IDLE;
      key_code   <= '0;
      key_strobe <= 1'b0;
    end else begin
      key_strobe <= 1'b0;
      if (scan_end) begin
        stable_cnt <= stable_nxt;
        prev_kind  <= res_kind;
        prev_code  <= res_code;
        // A stable result can never be MULTI, because MULTI forces the
        // count to zero.
        if (is_stable) begin
          case (state)
            ST_IDLE: begin
              if (res_kind == RES_SINGLE) begin
                state      <= ST_HELD;
                key_code   <= res_code;
                key_strobe <= 1'b1;
              end
            end
            default: begin
              // A different single key replaces the held key without
              // passing through IDLE. The same key is ignored however long
              // it is held.
              if (res_kind == RES_SINGLE && res_code != key_code) begin
                key_code   <= res_code;
                key_strobe <= 1'b1;
              end else if (res_kind == RES_NONE) begin
                state <= ST_IDLE;
              end
            end
          endcase
        end
      end
    end
  end

  assign key_valid = (state == ST_HELD);

  // --------------------------------------------------------------------------
  // Sticky flags. An ack in the same cycle as a strobe clears the old event,
  // while the new strobe keeps key_pending set. Because of that, overrun is
  // not raised.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_pending <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      key_pending <= key_strobe | (key_pending & ~key_ack);
      overrun     <= ~key_ack & (overrun | (key_strobe & key_pending));
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// ----------------------------------------------------------------------------
// tb_keypad_scanner
//
// Self-checking bench for keypad_scanner with SCAN_DIV=4 and DEBOUNCE_SCANS=3.
// A keypad model pulls a column low only while its row is driven. The
// reference model tracks the pressed-key set once per scan. It classifies
// each scan, keeps a short history of results, and decides commits from that
// history. Expected strobes go into a scoreboard queue, which an independent
// monitor drains whenever the DUT strobes. The main process also compares
// row_sel, key_code, key_valid, key_pending and overrun every cycle.
// ----------------------------------------------------------------------------
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;
  localparam int SCAN     = 4 * SCAN_DIV;

  logic       clk;
  logic       rst;
  logic [3:0] col_in;
  logic       key_ack;
  logic [3:0] row_sel;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_strobe;
  logic       key_pending;
  logic       overrun;

  logic [15:0] pressed;

  keypad_scanner #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DEB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .col_in      (col_in),
    .key_ack     (key_ack),
    .row_sel     (row_sel),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_strobe  (key_strobe),
    .key_pending (key_pending),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix: a closed key connects its column to its row.
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      if (row_sel[r] === 1'b0)
        for (int c = 0; c < 4; c++)
          if (pressed[r*4 + c]) col_in[c] = 1'b0;
  end

  typedef struct {
    int         cyc;
    logic [3:0] code;
    logic       valid;
    logic       strobe;
  } ev_t;

  typedef struct {
    int         cyc;
    logic [3:0] code;
  } sb_t;

  ev_t ev_q[$];
  sb_t sb_q[$];

  int cyc;
  int n_checks;
  int n_errors;
  int strobe_seen;
  int last_strobe_cyc;

  // Reference model state.
  logic [15:0] m_img;
  int          hist[$];
  logic        m_held;
  logic [3:0]  m_code;
  logic        m_pend;
  logic        m_ovr;
  logic [3:0]  e_code;
  logic        e_valid;
  logic        e_pend;
  logic        e_ovr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    ev_q.delete();
    sb_q.delete();
    hist.delete();
    m_img   = '0;
    m_held  = 1'b0;
    m_code  = '0;
    m_pend  = 1'b0;
    m_ovr   = 1'b0;
    e_code  = '0;
    e_valid = 1'b0;
    e_pend  = 1'b0;
    e_ovr   = 1'b0;
  endtask

  // One scan has completed. Encode the result as -1 (none), -2 (several),
  // or a key code.
  task automatic scan_done();
    int  n;
    int  res;
    bit  stable;
    bit  strobe;
    ev_t ev;
    n   = $countones(m_img);
    res = (n == 0) ? -1 : -2;
    if (n == 1)
      for (int i = 0; i < 16; i++) if (m_img[i]) res = i;
    hist.push_back(res);
    if (hist.size() > DEB) void'(hist.pop_front());
    stable = (hist.size() == DEB) && (res != -2);
    foreach (hist[i]) if (hist[i] != res) stable = 0;
    strobe = 0;
    if (stable) begin
      if (res >= 0 && (!m_held || 4'(res) != m_code)) begin
        m_held = 1'b1;
        m_code = 4'(res);
        strobe = 1;
      end else if (res == -1) begin
        m_held = 1'b0;
      end
    end
    // Outputs change in the cycle after the row-3 sample, which is two
    // cycles after the row-3 column value is captured.
    ev.cyc    = cyc + 3;
    ev.code   = m_code;
    ev.valid  = m_held;
    ev.strobe = strobe;
    ev_q.push_back(ev);
    if (strobe) sb_q.push_back('{cyc: cyc + 3, code: m_code});
  endtask

  task automatic model_step();
    bit  strobe_now;
    int  row;
    ev_t ev;
    strobe_now = 0;
    if (ev_q.size() > 0 && ev_q[0].cyc == cyc) begin
      ev         = ev_q.pop_front();
      e_code     = ev.code;
      e_valid    = ev.valid;
      strobe_now = ev.strobe;
    end
    e_pend = m_pend;
    e_ovr  = m_ovr;
    m_ovr  = !key_ack && (m_ovr || (strobe_now && m_pend));
    m_pend = strobe_now || (m_pend && !key_ack);
    // The column value seen in this cycle is the one sampled for this row,
    // after the two-flop synchronizer.
    if (cyc % SCAN_DIV == SCAN_DIV - 3) begin
      row = (cyc / SCAN_DIV) % 4;
      m_img[row*4 +: 4] = pressed[row*4 +: 4];
      if (row == 3) scan_done();
    end
  endtask

  // Called at the falling edge of cycle `cyc`, after stimulus is set.
  task automatic tick();
    logic [3:0] exp_row;
    model_step();
    exp_row = ~(4'b0001 << ((cyc / SCAN_DIV) % 4));
    check("row_sel", row_sel, exp_row);
    check("key_code", key_code, e_code);
    check("key_valid", key_valid, e_valid);
    check("key_pending", key_pending, e_pend);
    check("overrun", overrun, e_ovr);
    @(negedge clk);
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic align();
    while (cyc % SCAN != 0) tick();
  endtask

  task automatic ack_pulse();
    key_ack = 1'b1;
    tick();
    key_ack = 1'b0;
  endtask

  task automatic do_reset(input int hold);
    rst = 1'b0;
    #2;
    check("rst_row_sel", row_sel, 4'b1110);
    check("rst_key_code", key_code, 4'h0);
    check("rst_key_valid", key_valid, 1'b0);
    check("rst_key_strobe", key_strobe, 1'b0);
    check("rst_key_pending", key_pending, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    model_reset();
    repeat (hold) @(negedge clk);
    rst = 1'b1;
    cyc = 0;
  endtask

  // Scoreboard monitor: runs on its own, away from the clock edges.
  initial begin
    sb_t item;
    forever begin
      @(negedge clk);
      #1;
      if (rst === 1'b1) begin
        if (key_strobe === 1'b1) begin
          strobe_seen++;
          last_strobe_cyc = cyc;
          if (sb_q.size() == 0) begin
            check("unexpected_strobe", key_strobe, 1'b0);
          end else begin
            item = sb_q.pop_front();
            check("strobe_cycle", cyc, item.cyc);
            check("strobe_code", key_code, item.code);
          end
        end else if (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
          item = sb_q.pop_front();
          check("missed_strobe_due_cycle", cyc - 1, item.cyc);
        end
      end
    end
  end

  initial begin
    int base;
    int t0;
    rst             = 1'b0;
    key_ack         = 1'b0;
    pressed         = '0;
    cyc             = 0;
    n_checks        = 0;
    n_errors        = 0;
    strobe_seen     = 0;
    last_strobe_cyc = -1;
    model_reset();

    @(negedge clk);
    do_reset(2);

    // 1. Idle: rows cycle and nothing is reported.
    run(20 * SCAN);
    check("t1_no_strobe", strobe_seen, 0);

    // 2. Single key, row 2 column 1.
    align();
    t0 = cyc;
    pressed = 16'(1) << 9;
    run(6 * SCAN);
    check("t2_strobes", strobe_seen, 1);
    check("t2_latency", last_strobe_cyc, t0 + 3 * SCAN);
    check("t2_code", key_code, 4'h9);
    check("t2_valid", key_valid, 1'b1);
    check("t2_pending", key_pending, 1'b1);
    pressed = '0;
    run(5 * SCAN);
    check("t2_release_valid", key_valid, 1'b0);
    check("t2_release_code", key_code, 4'h9);
    ack_pulse();
    run(2);

    // 3. Bounce on key 5 (period 20 cycles), then a steady hold.
    align();
    base = strobe_seen;
    for (int i = 0; i < 8 * SCAN; i++) begin
      pressed = (((i + 5) / 10) % 2 == 0) ? (16'(1) << 5) : 16'h0000;
      tick();
    end
    check("t3_no_strobe_bouncing", strobe_seen, base);
    pressed = 16'(1) << 5;
    run(6 * SCAN);
    check("t3_one_strobe", strobe_seen, base + 1);
    check("t3_code", key_code, 4'h5);
    pressed = '0;
    run(5 * SCAN);
    ack_pulse();

    // 4. Ghosting: keys 0 and 15 together, then only key 0.
    base = strobe_seen;
    pressed = 16'h8001;
    run(6 * SCAN);
    check("t4_multi_no_strobe", strobe_seen, base);
    check("t4_multi_valid", key_valid, 1'b0);
    pressed = 16'h0001;
    run(5 * SCAN);
    check("t4_single_strobe", strobe_seen, base + 1);
    check("t4_code", key_code, 4'h0);
    pressed = '0;
    run(5 * SCAN);
    ack_pulse();
    run(1);

    // 5. Flags: overrun, ack clearing, and ack coincident with a strobe.
    pressed = 16'(1) << 3;
    run(5 * SCAN);
    pressed = '0;
    run(5 * SCAN);
    pressed = 16'(1) << 7;
    run(5 * SCAN);
    check("t5_overrun", overrun, 1'b1);
    check("t5_code", key_code, 4'h7);
    ack_pulse();
    check("t5_ack_pending", key_pending, 1'b0);
    check("t5_ack_overrun", overrun, 1'b0);
    pressed = 16'(1) << 2;
    run(5 * SCAN);
    pressed = '0;
    run(5 * SCAN);
    pressed = 16'(1) << 2;
    for (int i = 0; i < 5 * SCAN; i++) begin
      key_ack = (ev_q.size() > 0 && ev_q[0].cyc == cyc && ev_q[0].strobe) ? 1'b1 : 1'b0;
      tick();
    end
    key_ack = 1'b0;
    check("t5_coincident_pending", key_pending, 1'b1);
    check("t5_coincident_overrun", overrun, 1'b0);
    pressed = '0;
    run(5 * SCAN);

    // 6. Reset during the second stable scan of a new key.
    pressed = 16'(1) << 1;
    run(5 * SCAN);
    align();
    pressed = 16'(1) << 6;
    run(SCAN + 8);
    do_reset(2);
    base = strobe_seen;
    run(3 * SCAN - 1);
    check("t6_no_early_strobe", strobe_seen, base);
    run(2);
    check("t6_strobe_after_debounce", strobe_seen, base + 1);
    check("t6_strobe_cycle", last_strobe_cyc, 3 * SCAN);
    check("t6_code", key_code, 4'h6);
    pressed = '0;
    run(5 * SCAN);
    ack_pulse();

    // Randomized presses, ghost pairs, releases and sporadic acks.
    for (int seg = 0; seg < 60; seg++) begin
      int kind;
      int dur;
      kind = $urandom_range(0, 9);
      if (kind < 3)
        pressed = '0;
      else if (kind < 9)
        pressed = 16'(1) << $urandom_range(0, 15);
      else
        pressed = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
      dur = $urandom_range(5, 80);
      for (int i = 0; i < dur; i++) begin
        key_ack = ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0;
        tick();
      end
      key_ack = 1'b0;
      if (seg == 30) do_reset(1);
    end
    pressed = '0;
    run(6 * SCAN);

    check("scoreboard_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
